poly_io_ctrl: RTL

//  Host-side load/unload controller for the multi-lane NTT core (polytop_RE).

---
 rtl/poly_io_ctrl_pkg.sv | 36 +++
 rtl/poly_io_ctrl_if.sv | 45 ++++
 rtl/poly_io_fifo2.sv | 48 ++++
 rtl/poly_io_ctrl.sv | 137 +++++++++++++
 4 files changed

// File: rtl/poly_io_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | poly_io_ctrl_pkg : shared sizes, FSM states and bank-map helper       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package poly_io_ctrl_pkg;

  localparam int DATA_WIDTH = 12;
  localparam int N          = 256;
  localparam int P          = 4;
  localparam int BANKS      = 2 * P;
  localparam int BANK_AW    = 5;
  localparam int SEL_W      = 3;
  localparam int K_W        = 8;
  localparam int OPC_W      = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DRAIN = 3'd4
  } state_e;

  typedef struct packed {
    logic                  last;
    logic [DATA_WIDTH-1:0] data;
  } beat_t;

  // Skewed map: row k[7:3] rotates the bank by its own index, mod BANKS.
  function automatic logic [SEL_W-1:0] bank_sel(input logic [K_W-1:0] k);
    return k[SEL_W-1:0] + k[2*SEL_W-1:SEL_W];
  endfunction

endpackage
`default_nettype wire

// File: rtl/poly_io_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | poly_io_ctrl_if : command, stream, bank and core signals              |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface poly_io_ctrl_if;
  import poly_io_ctrl_pkg::*;

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [OPC_W-1:0]      cmd_opcode;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_last;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;
  logic                  bk_wen;
  logic                  bk_ren;
  logic [SEL_W-1:0]      bk_sel;
  logic [BANK_AW-1:0]    bk_addr;
  logic [DATA_WIDTH-1:0] bk_wdata;
  logic [DATA_WIDTH-1:0] bk_rdata;
  logic [OPC_W-1:0]      core_opcode;
  logic                  core_start;
  logic                  core_finish;
  logic                  busy;
  logic                  err;

  modport slave (
    input  cmd_valid, cmd_opcode, in_valid, in_data, in_last, out_ready, bk_rdata, core_finish,
    output cmd_ready, in_ready, out_valid, out_data, out_last, bk_wen, bk_ren, bk_sel, bk_addr,
           bk_wdata, core_opcode, core_start, busy, err
  );

  modport master (
    output cmd_valid, cmd_opcode, in_valid, in_data, in_last, out_ready, bk_rdata, core_finish,
    input  cmd_ready, in_ready, out_valid, out_data, out_last, bk_wen, bk_ren, bk_sel, bk_addr,
           bk_wdata, core_opcode, core_start, busy, err
  );

endinterface
`default_nettype wire

// File: rtl/poly_io_fifo2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | poly_io_fifo2 : 2-entry FIFO with occupancy count for read credits    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module poly_io_fifo2 #(
  parameter int WIDTH = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  output logic             pop_valid_o,
  input  logic             pop_ready_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic [1:0]       count_o
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;
  logic             do_pop;

  // The writer only pushes against a granted credit, so no full check here.
  assign pop_valid_o = (count_q != 2'd0);
  assign do_pop      = pop_valid_o && pop_ready_i;
  assign pop_data_o  = mem_q[rd_ptr_q];
  assign count_o     = count_q;

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_i) wr_ptr_q <= ~wr_ptr_q;
      if (do_pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, push_i} - {1'b0, do_pop};
    end
  end

endmodule
`default_nettype wire

// File: rtl/poly_io_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | poly_io_ctrl : load/unload controller for the banked NTT core         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module poly_io_ctrl
  import poly_io_ctrl_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  poly_io_ctrl_if.slave  bus
);

  state_e           state_q, state_d;
  logic [K_W-1:0]   k_q, k_d;
  logic [OPC_W-1:0] opcode_q, opcode_d;
  logic             err_q, err_d;
  logic             issued_all_q, issued_all_d;
  logic             rd_pend_q;
  logic             rd_last_q;

  logic             in_beat;
  logic             ren;
  logic             k_term;
  logic             out_beat;
  logic             fifo_valid;
  logic [1:0]       fifo_count;
  logic [1:0]       inflight;
  beat_t            fifo_head;
  beat_t            fifo_in;

  assign k_term   = (k_q == K_W'(N - 1));
  assign in_beat  = (state_q == ST_LOAD) && bus.in_valid;
  assign out_beat = fifo_valid && bus.out_ready;

  // A beat leaving this cycle frees its slot, keeping the drain at one beat per cycle.
  assign inflight = fifo_count + {1'b0, rd_pend_q} - {1'b0, out_beat};
  assign ren      = (state_q == ST_DRAIN) && !issued_all_q && (inflight < 2'd2);
  assign fifo_in  = '{last: rd_last_q, data: bus.bk_rdata};

  poly_io_fifo2 #(.WIDTH($bits(beat_t))) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (rd_pend_q),
    .push_data_i (fifo_in),
    .pop_valid_o (fifo_valid),
    .pop_ready_i (bus.out_ready),
    .pop_data_o  (fifo_head),
    .count_o     (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      k_q          <= '0;
      opcode_q     <= '0;
      err_q        <= 1'b0;
      issued_all_q <= 1'b0;
      rd_pend_q    <= 1'b0;
      rd_last_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      opcode_q     <= opcode_d;
      err_q        <= err_d;
      issued_all_q <= issued_all_d;
      rd_pend_q    <= ren;
      rd_last_q    <= ren && k_term;
    end
  end

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    opcode_d     = opcode_q;
    err_d        = err_q;
    issued_all_d = issued_all_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          opcode_d     = bus.cmd_opcode;
          err_d        = 1'b0;
          k_d          = '0;
          issued_all_d = 1'b0;
          state_d      = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (in_beat) begin
          // Terminal count always proceeds; a missing in_last there is still flagged.
          if (k_term) begin
            err_d   = err_q | ~bus.in_last;
            state_d = ST_START;
          end else if (bus.in_last) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      ST_START: state_d = ST_WAIT;
      ST_WAIT: begin
        if (bus.core_finish) begin
          k_d          = '0;
          issued_all_d = 1'b0;
          state_d      = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (ren) begin
          if (k_term) issued_all_d = 1'b1;
          else        k_d = k_q + 1'b1;
        end
        if (out_beat && fifo_head.last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.cmd_ready   = (state_q == ST_IDLE);
  assign bus.in_ready    = (state_q == ST_LOAD);
  assign bus.bk_wen      = in_beat;
  assign bus.bk_ren      = ren;
  assign bus.bk_sel      = bank_sel(k_q);
  assign bus.bk_addr     = k_q[K_W-1:SEL_W];
  assign bus.bk_wdata    = in_beat ? bus.in_data : '0;
  assign bus.out_valid   = fifo_valid;
  assign bus.out_data    = fifo_valid ? fifo_head.data : '0;
  assign bus.out_last    = fifo_valid && fifo_head.last;
  assign bus.core_opcode = opcode_q;
  assign bus.core_start  = (state_q == ST_START);
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.err         = err_q;

endmodule
`default_nettype wire
